// File: rtl/crypto_sched_pkg.sv
// Shared opcodes, error codes, widths, FSM encoding and job record
// for the crypto job scheduler.
package crypto_sched_pkg;

  localparam int TS_W   = 64;
  localparam int DATA_W = 256;

  localparam logic [1:0] OP_PUF  = 2'd0;
  localparam logic [1:0] OP_HASH = 2'd1;
  localparam logic [1:0] OP_LFSR = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_STALE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BADOP   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } job_t;

endpackage

// File: rtl/crypto_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int              cand;
    logic [IDXW-1:0] cand_idx;
    gnt      = '0;
    gnt_idx  = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDXW'(cand);
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/crypto_job_scheduler.sv
// Shares one multi-cycle crypto engine among NREQ requesters: arbitrate, check
// freshness, issue, respond. Define CRYPTO_SCHED_STATS_EN for saturating stat counters.
//   state | meaning
//   IDLE  | arbitrate and accept one request
//   CHECK | timestamp age and opcode check
//   ISSUE | one-cycle start to the engine
//   WAIT  | wait for engine done or timeout
//   RESP  | one-cycle response to the winner
module crypto_job_scheduler
  import crypto_sched_pkg::*;
#(
  parameter int NREQ             = 4,
  parameter int ACCEPTABLE_DELAY = 10,
  parameter int TIMEOUT          = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [TS_W*NREQ-1:0]   req_ts,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic                   eng_start,
  output logic                   eng_abort,
  output logic [1:0]             eng_op,
  output logic [DATA_W-1:0]      eng_data,
  input  logic                   eng_done,
  input  logic [63:0]            eng_result,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [63:0]            rsp_result,
  output logic [1:0]             rsp_err,
  output logic [TS_W-1:0]        now
`ifdef CRYPTO_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_grants,
  output logic [15:0]            stat_stale,
  output logic [15:0]            stat_timeout
`endif
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_RESP  = ST_RESP;

  logic [2:0]        state_q, state_d;
  logic [IDXW-1:0]   last_grant_q, last_grant_d, win_q, win_d;
  job_t              job_q, job_d;
  logic [1:0]        err_q, err_d;
  logic [63:0]       result_q, result_d;
  logic [CNTW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TS_W-1:0]   now_q, age;
  logic [NREQ-1:0]   arb_gnt;
  logic [IDXW-1:0]   arb_idx;
  logic              arb_any, accept, stale, timed_out, eng_busy;
  logic [1:0]        op_arr   [NREQ];
  logic [TS_W-1:0]   ts_arr   [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i]   = req_op[2*i +: 2];
    assign ts_arr[i]   = req_ts[TS_W*i +: TS_W];
    assign data_arr[i] = req_data[DATA_W*i +: DATA_W];
  end

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .any       (arb_any)
  );

  // Modulo-2^64 age: a future timestamp wraps to a huge value and reads as stale.
  assign age       = now_q - job_q.ts;
  assign accept    = (state_q == S_IDLE) && arb_any;
  assign stale     = (state_q == S_CHECK) && (age > TS_W'(ACCEPTABLE_DELAY));
  assign timed_out = (state_q == S_WAIT) && !eng_done && (wait_cnt_q == CNTW'(TIMEOUT-1));
  assign eng_busy  = (state_q == S_ISSUE) || (state_q == S_WAIT);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    job_d        = job_q;
    err_d        = err_q;
    result_d     = result_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d      = S_CHECK;
        last_grant_d = arb_idx;
        win_d        = arb_idx;
        job_d.op     = op_arr[arb_idx];
        job_d.ts     = ts_arr[arb_idx];
        job_d.data   = data_arr[arb_idx];
        err_d        = ERR_NONE;
        result_d     = '0;
      end
      S_CHECK: begin
        if (stale) begin
          err_d   = ERR_STALE;
          state_d = S_RESP;
        end else if (job_q.op == OP_RSVD) begin
          err_d   = ERR_BADOP;
          state_d = S_RESP;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          result_d = eng_result;
          err_d    = ERR_NONE;
          state_d  = S_RESP;
        end else if (timed_out) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNTW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDXW'(NREQ-1);
      win_q        <= '0;
      job_q        <= '0;
      err_q        <= ERR_NONE;
      result_q     <= '0;
      wait_cnt_q   <= '0;
      now_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      job_q        <= job_d;
      err_q        <= err_d;
      result_q     <= result_d;
      wait_cnt_q   <= wait_cnt_d;
      now_q        <= now_q + TS_W'(1);
    end
  end

  // Masked while rst is low so nothing looks accepted while the block is held.
  assign req_ready  = (accept && rst) ? arb_gnt : '0;
  assign eng_start  = (state_q == S_ISSUE);
  assign eng_abort  = timed_out;
  assign eng_op     = eng_busy ? job_q.op : 2'b00;
  assign eng_data   = eng_busy ? job_q.data : '0;
  assign rsp_valid  = (state_q == S_RESP) ? (NREQ'(1) << win_q) : '0;
  assign rsp_result = (state_q == S_RESP) ? result_q : '0;
  assign rsp_err    = (state_q == S_RESP) ? err_q : ERR_NONE;
  assign now        = now_q;

`ifdef CRYPTO_SCHED_STATS_EN
  logic [15:0] grants_q, stale_q, tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grants_q <= '0;
      stale_q  <= '0;
      tmo_q    <= '0;
    end else begin
      if (accept && grants_q != 16'hFFFF)    grants_q <= grants_q + 16'd1;
      if (stale && stale_q != 16'hFFFF)      stale_q  <= stale_q + 16'd1;
      if (timed_out && tmo_q != 16'hFFFF)    tmo_q    <= tmo_q + 16'd1;
    end
  end

  assign stat_grants  = grants_q;
  assign stat_stale   = stale_q;
  assign stat_timeout = tmo_q;
`endif

endmodule

// File: tb/tb_crypto_job_scheduler.sv
// Table-driven bench for crypto_job_scheduler: one record per job, plus a
// hand-written reset-during-WAIT sequence.
module tb_crypto_job_scheduler;
  import crypto_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int DELAY = 10;
  localparam int TMO   = 64;
  localparam int NVEC  = 13;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid, req_ready, rsp_valid;
  logic [2*NREQ-1:0]      req_op;
  logic [TS_W*NREQ-1:0]   req_ts;
  logic [DATA_W*NREQ-1:0] req_data;
  logic                   eng_start, eng_abort, eng_done;
  logic [1:0]             eng_op, rsp_err;
  logic [DATA_W-1:0]      eng_data;
  logic [63:0]            eng_result, rsp_result;
  logic [TS_W-1:0]        now;
`ifdef CRYPTO_SCHED_STATS_EN
  logic [15:0]            stat_grants, stat_stale, stat_timeout;
`endif

  crypto_job_scheduler #(.NREQ(NREQ), .ACCEPTABLE_DELAY(DELAY), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_ts    (req_ts),
    .req_data  (req_data),
    .eng_start (eng_start),
    .eng_abort (eng_abort),
    .eng_op    (eng_op),
    .eng_data  (eng_data),
    .eng_done  (eng_done),
    .eng_result(eng_result),
    .rsp_valid (rsp_valid),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err),
    .now       (now)
`ifdef CRYPTO_SCHED_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stale  (stat_stale),
    .stat_timeout(stat_timeout)
`endif
  );

  always #5 clk = ~clk;

  // age is the intended now-ts in the CHECK cycle; done_dly counts cycles from eng_start (-1 = never)
  typedef struct {
    logic [NREQ-1:0] mask;
    logic [1:0]      op;
    int              age;
    int              done_dly;
    logic [63:0]     res;
    logic [NREQ-1:0] exp_gnt;
    logic [1:0]      exp_err;
    logic [63:0]     exp_res;
  } vec_t;

  vec_t tbl [NVEC];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_stale = 0;
  int   exp_tmo = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_for(input int v, input int i);
    return {8{32'(32'hC0DE_0000 + v*16 + i)}};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'hF, OP_PUF,  1,   5,  64'h1234,              4'h1, ERR_NONE,    64'h1234};
    tbl[1]  = '{4'hF, OP_HASH, 0,   1,  64'hAAAA_0001,         4'h2, ERR_NONE,    64'hAAAA_0001};
    tbl[2]  = '{4'hF, OP_LFSR, 5,   2,  64'h5555,              4'h4, ERR_NONE,    64'h5555};
    tbl[3]  = '{4'hF, OP_PUF,  10,  3,  64'hFFFF_FFFF_FFFF_FFFF, 4'h8, ERR_NONE,  64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4]  = '{4'hF, OP_HASH, 2,   1,  64'h0,                 4'h1, ERR_NONE,    64'h0};
    tbl[5]  = '{4'h1, OP_PUF,  1,   5,  64'h1234,              4'h1, ERR_NONE,    64'h1234};
    tbl[6]  = '{4'h2, OP_HASH, 11,  -1, 64'h0,                 4'h2, ERR_STALE,   64'h0};
    tbl[7]  = '{4'h4, OP_LFSR, 10,  4,  64'hC0FFEE,            4'h4, ERR_NONE,    64'hC0FFEE};
    tbl[8]  = '{4'h8, OP_PUF,  -1,  -1, 64'h0,                 4'h8, ERR_STALE,   64'h0};
    tbl[9]  = '{4'h1, OP_RSVD, 1,   -1, 64'h0,                 4'h1, ERR_BADOP,   64'h0};
    tbl[10] = '{4'h2, OP_HASH, 1,   -1, 64'h0,                 4'h2, ERR_TIMEOUT, 64'h0};
    tbl[11] = '{4'h4, OP_PUF,  1,   TMO, 64'h7777,             4'h4, ERR_NONE,    64'h7777};
    tbl[12] = '{4'h9, OP_LFSR, 200, -1, 64'h0,                 4'h8, ERR_STALE,   64'h0};

    rst = 1'b0; req_valid = '0; req_op = '0; req_ts = '0; req_data = '0;
    eng_done = 1'b0; eng_result = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_now", now, 0);
    chk("rst_ctrl", {req_ready, eng_start, eng_abort, eng_op, rsp_valid, rsp_err}, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst = 1'b1;

    for (int vi = 0; vi < NVEC; vi++) begin
      vec_t            tv;
      logic [63:0]     n, ts, rr;
      logic [NREQ-1:0] rv;
      logic [1:0]      re;
      int              widx, s, a, r, nstart, nabort;
      bit              seen;
      @(posedge clk);
      #1;
      tv = tbl[vi];
      if (tv.exp_err == ERR_STALE)   exp_stale++;
      if (tv.exp_err == ERR_TIMEOUT) exp_tmo++;
      chk("idle_rsp_quiet", rsp_valid, 0);
      n  = now;
      ts = n + 64'd1 - 64'(tv.age);
      req_op = {NREQ{tv.op}};
      req_ts = {NREQ{ts}};
      for (int i = 0; i < NREQ; i++) req_data[DATA_W*i +: DATA_W] = data_for(vi, i);
      req_valid = tv.mask;
      eng_done  = 1'b0;
      #1;
      chk("req_ready", req_ready, tv.exp_gnt);
      widx = 0;
      for (int i = 0; i < NREQ; i++) if (tv.exp_gnt[i]) widx = i;
      s = -1; a = -1; r = -1; nstart = 0; nabort = 0; seen = 1'b0;
      rv = '0; re = '0; rr = '0;
      for (int k = 1; k <= 200 && !seen; k++) begin
        @(posedge clk);
        #1;
        eng_done   = (k == 1);  // stray done during CHECK must be ignored
        eng_result = 64'hBAD0_BAD0_BAD0_BAD0;
        if (tv.done_dly >= 0 && s >= 0 && k == s + tv.done_dly) begin
          eng_done   = 1'b1;
          eng_result = tv.res;
        end
        #1;
        if (k == 1) begin
          chk("check_eng_op_zero", eng_op, 0);
          chk("check_eng_data_zero", eng_data, 0);
        end
        if (eng_start) begin
          nstart++;
          if (s < 0) begin
            s = k;
            chk("eng_op", eng_op, tv.op);
            chk("eng_data", eng_data, data_for(vi, widx));
          end
        end
        if (eng_abort) begin
          nabort++;
          a = k;
        end
        if (rsp_valid != '0) begin
          seen = 1'b1;
          r  = k;
          rv = rsp_valid;
          re = rsp_err;
          rr = rsp_result;
          chk("rsp_vs_ready", req_ready, 0);
        end
      end
      eng_done = 1'b0;
      chk("rsp_seen", seen, 1);
      chk("rsp_valid", rv, tv.exp_gnt);
      chk("rsp_err", re, tv.exp_err);
      chk("rsp_result", rr, tv.exp_res);
      if (tv.exp_err == ERR_STALE || tv.exp_err == ERR_BADOP) begin
        chk("no_engine_use", nstart, 0);
        chk("err_rsp_latency", r, 2);
      end else begin
        chk("n_start", nstart, 1);
        chk("start_latency", s, 2);
        if (tv.exp_err == ERR_TIMEOUT) begin
          chk("n_abort", nabort, 1);
          chk("abort_after_issue", a - s, TMO);
          chk("timeout_rsp_latency", r - a, 1);
        end else begin
          chk("n_abort", nabort, 0);
          chk("done_rsp_latency", r - (s + tv.done_dly), 1);
        end
      end
    end

`ifdef CRYPTO_SCHED_STATS_EN
    chk("stat_grants", stat_grants, 16'(NVEC));
    chk("stat_stale", stat_stale, 16'(exp_stale));
    chk("stat_timeout", stat_timeout, 16'(exp_tmo));
`endif

    // Reset while a job sits in WAIT: everything clears at once, no abort.
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    req_op    = {NREQ{OP_HASH}};
    req_ts    = {NREQ{now}};
    #1;
    chk("pre_rst_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("wait_busy_data", eng_data, data_for(NVEC-1, 2));
    rst       = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("midrst_now", now, 0);
    chk("midrst_ctrl", {req_ready, eng_start, eng_abort, eng_op, rsp_valid, rsp_err}, 0);
    chk("midrst_eng_data", eng_data, 0);
    chk("midrst_rsp_result", rsp_result, 0);
`ifdef CRYPTO_SCHED_STATS_EN
    chk("midrst_stats", {stat_grants, stat_stale, stat_timeout}, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("first_grant_after_rst", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("now_after_rst", now, 1);
    chk("no_start_in_check", eng_start, 0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crypto_job_scheduler.md
# crypto_job_scheduler

- Shares one multi-cycle crypto engine (PUF / hash192 / LFSR step) among `NREQ` protocol requesters: EV-USP registration, CS-USP registration, EV-CS authentication and one spare.
- Each job passes through four steps: round-robin arbitration, a timestamp freshness check against an internal time base, an engine issue, and a single response pulse back to the winner.
- Stale and hung jobs are rejected with an error code; stale jobs never occupy the engine.

## Interface
Parameters:
- `NREQ`, 4, number of requesters.
- `ACCEPTABLE_DELAY`, 10, maximum allowed `now - ts` in cycles.
- `TIMEOUT`, 64, maximum number of cycles in WAIT before abort.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester job request; held until accepted.
- `req_ready` out NREQ: one-hot; high for one cycle on the accepting edge.
- `req_op` in 2*NREQ: opcode per requester, slice `[2i+1:2i]`.
- `req_ts` in 64*NREQ: request timestamp per requester.
- `req_data` in 256*NREQ: operand per requester.
- `eng_start` out 1: one-cycle pulse to the engine.
- `eng_abort` out 1: one-cycle pulse on timeout.
- `eng_op` out 2: opcode presented to the engine.
- `eng_data` out 256: operand presented to the engine.
- `eng_done` in 1: engine completion, one cycle.
- `eng_result` in 64: valid when `eng_done` is high.
- `rsp_valid` out NREQ: one-hot response pulse.
- `rsp_result` out 64: engine result, or 0 on error.
- `rsp_err` out 2: error code for the response.
- `now` out 64: free-running time base.

## Operation
State machine: IDLE → CHECK → ISSUE → WAIT → RESP → IDLE.

- **IDLE**
  - If any `req_valid` is high, the arbiter picks the first valid requester at or after `last_grant+1`, wrapping modulo NREQ.
  - On that edge: assert `req_ready[winner]`, capture op/ts/data into job registers, set `last_grant` = winner, go to CHECK.
- **CHECK**
  - `age = now - job_ts`, computed modulo 2^64.
  - `age > ACCEPTABLE_DELAY` → `err = ERR_STALE`, go to RESP. A future timestamp wraps to a huge age and is therefore stale.
  - `op == OP_RSVD` → `err = ERR_BADOP`, go to RESP.
  - Otherwise go to ISSUE.
- **ISSUE**: `eng_start = 1` for one cycle with `eng_op` / `eng_data`; clear `wait_cnt`; go to WAIT.
- **WAIT**
  - `eng_done` → latch `eng_result`, `err = ERR_NONE`, go to RESP.
  - Otherwise, when `wait_cnt == TIMEOUT-1`, pulse `eng_abort`, set `err = ERR_TIMEOUT`, go to RESP.
  - If `eng_done` and the timeout arrive in the same cycle, `eng_done` wins.
- **RESP**: `rsp_valid[winner] = 1` for one cycle with `rsp_result` / `rsp_err`; go to IDLE.
- `eng_done` outside WAIT is ignored.
- `eng_op` / `eng_data` hold the job values from ISSUE through WAIT, and are 0 otherwise.
- `now` increments every cycle and wraps at 2^64.
- `req_valid` deasserted before acceptance withdraws the request; no response is produced.

## Timing
- Reset values:
  - All outputs 0; `now` = 0.
  - `last_grant` = NREQ-1, so requester 0 wins first.
  - State = IDLE.
- Reset mid-job: all state, counters and pulses clear immediately; no `eng_abort` is issued. The engine is reset by the same `rst`.
- Latency:
  - Accept edge to `eng_start`: 2 cycles.
  - `eng_done` to `rsp_valid`: 1 cycle.
  - Stale/badop accept edge to `rsp_valid`: 2 cycles.
- Throughput: at most one job in flight. The next accept occurs in the IDLE cycle that follows RESP.
- `rsp_valid` and `req_ready` never fire in the same cycle.

## Configuration
- `CRYPTO_SCHED_STATS_EN` defined:
  - Adds output ports `stat_grants`, `stat_stale` and `stat_timeout`, each 16 bits.
  - These count accepts, ERR_STALE and ERR_TIMEOUT respectively, and saturate at 16'hFFFF.
  - All reset to 0.
- `CRYPTO_SCHED_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `crypto_sched_pkg` holds:
  - Opcodes: `OP_PUF` = 0, `OP_HASH` = 1, `OP_LFSR` = 2, `OP_RSVD` = 3.
  - Error codes: `ERR_NONE` = 0, `ERR_STALE` = 1, `ERR_TIMEOUT` = 2, `ERR_BADOP` = 3.
  - The state enum.
  - Width constants `TS_W` = 64 and `DATA_W` = 256.
- Sub-module `rr_arbiter`: a combinational NREQ-way round-robin pick.
  - Inputs: `req`, `last_grant`.
  - Outputs: one-hot `gnt`, `gnt_idx`, `any`.
  - The scheduler owns the `last_grant` register.

## Test plan
- **Single job:** req0 valid, op = OP_PUF, ts = now.
  - Expect `req_ready[0]` on the accept edge and `eng_start` 2 cycles later.
  - Engine returns done after 5 cycles with result 64'h1234 → `rsp_valid[0]`, `rsp_result` = 64'h1234, `rsp_err` = 0.
- **Round-robin:** req0–req3 all valid continuously. Grants go 0, 1, 2, 3, 0 across five jobs, each producing exactly one `rsp_valid` to the matching index.
- **Freshness:**
  - ts = now-11 → ERR_STALE; no `eng_start`.
  - ts = now-10 → accepted.
  - ts = now+1 → ERR_STALE (wrap).
- **Timeout:** engine never asserts done → `eng_abort` pulses exactly TIMEOUT cycles after ISSUE; response carries ERR_TIMEOUT and result 0.
  - Variant: done coincident with the final wait cycle → ERR_NONE.
- **Bad op and reset:**
  - op = 3 → ERR_BADOP; no engine use.
  - Assert `rst` low during WAIT → all outputs 0 immediately.
  - After release, requester 0 wins first.
- **Stats (`CRYPTO_SCHED_STATS_EN`):** after 3 good, 2 stale and 1 timeout jobs → `stat_grants` = 6, `stat_stale` = 2, `stat_timeout` = 1.
